// File: rtl/heartbeat_generator.sv
// rtl/heartbeat_generator.sv - periodic keepalive request generator with ack timeout and fault latch; optional jitter via HB_JITTER_EN
module heartbeat_generator #(
    parameter int CLK_FREQ    = 125_000_000,
    parameter int MAX_MISSED  = 3,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        pause,
    input  logic        fault_clear,
    input  logic [15:0] period_ms,
    input  logic        hb_ack,
    output logic        hb_req,
    output logic        hb_pulse,
    output logic [15:0] hb_count,
    output logic [3:0]  missed_count,
    output logic        fault,
    output logic [1:0]  state
);

    localparam int CYCLES_PER_MS = CLK_FREQ / 1000;
    localparam int PRE_W = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
    localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_WAIT  = 2'b01;
    localparam logic [1:0] ST_REQ   = 2'b10;
    localparam logic [1:0] ST_FAULT = 2'b11;

    localparam logic [PRE_W-1:0] PRE_TOP = PRE_W'(CYCLES_PER_MS - 1);
    localparam logic [TMO_W-1:0] TMO_TOP = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [3:0]       MISS_MAX = 4'(MAX_MISSED);

    logic [PRE_W-1:0] presc;
    logic [16:0]      ms_cnt;
    logic [16:0]      target;
    logic [TMO_W-1:0] ack_timer;
    logic [15:0]      p_eff;
    logic [16:0]      next_target;
    logic [3:0]       missed_inc;

    assign p_eff      = (period_ms == 16'd0) ? 16'd1 : period_ms;
    assign missed_inc = (missed_count == MISS_MAX) ? missed_count : missed_count + 4'd1;

`ifdef HB_JITTER_EN
    logic [7:0] lfsr;
    logic       lfsr_fb;
    assign lfsr_fb     = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign next_target = {1'b0, p_eff} + {14'd0, lfsr[2:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 8'hA5;
        end else if (enable && state == ST_WAIT && !pause && presc == PRE_TOP
                     && ms_cnt + 17'd1 == target) begin
            lfsr <= {lfsr[6:0], lfsr_fb};
        end
    end
`else
    assign next_target = {1'b0, p_eff};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            hb_req       <= 1'b0;
            hb_pulse     <= 1'b0;
            hb_count     <= 16'd0;
            missed_count <= 4'd0;
            fault        <= 1'b0;
            presc        <= '0;
            ms_cnt       <= 17'd0;
            target       <= 17'd0;
            ack_timer    <= '0;
        end else begin
            hb_pulse <= 1'b0;
            if (!enable) begin
                state        <= ST_IDLE;
                hb_req       <= 1'b0;
                fault        <= 1'b0;
                missed_count <= 4'd0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state  <= ST_WAIT;
                        presc  <= '0;
                        ms_cnt <= 17'd0;
                        target <= next_target;
                    end
                    ST_WAIT: begin
                        if (!pause) begin
                            if (presc == PRE_TOP) begin
                                presc <= '0;
                                if (ms_cnt + 17'd1 == target) begin
                                    state     <= ST_REQ;
                                    hb_req    <= 1'b1;
                                    ack_timer <= '0;
                                end else begin
                                    ms_cnt <= ms_cnt + 17'd1;
                                end
                            end else begin
                                presc <= presc + 1'b1;
                            end
                        end
                    end
                    ST_REQ: begin
                        // An ack in the timeout cycle still counts as accepted.
                        if (hb_ack) begin
                            hb_req       <= 1'b0;
                            hb_pulse     <= 1'b1;
                            hb_count     <= hb_count + 16'd1;
                            missed_count <= 4'd0;
                            state        <= ST_WAIT;
                            presc        <= '0;
                            ms_cnt       <= 17'd0;
                            target       <= next_target;
                        end else if (ack_timer == TMO_TOP) begin
                            hb_req       <= 1'b0;
                            missed_count <= missed_inc;
                            if (missed_inc == MISS_MAX) begin
                                state <= ST_FAULT;
                                fault <= 1'b1;
                            end else begin
                                state  <= ST_WAIT;
                                presc  <= '0;
                                ms_cnt <= 17'd0;
                                target <= next_target;
                            end
                        end else begin
                            ack_timer <= ack_timer + 1'b1;
                        end
                    end
                    default: begin
                        if (fault_clear) begin
                            fault        <= 1'b0;
                            missed_count <= 4'd0;
                            state        <= ST_WAIT;
                            presc        <= '0;
                            ms_cnt       <= 17'd0;
                            target       <= next_target;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_heartbeat_generator.sv
// tb/tb_heartbeat_generator.sv - self-checking bench for heartbeat_generator
module tb_heartbeat_generator;

    localparam int CPM = 1;
    localparam int MAXM = 3;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        pause = 1'b0;
    logic        fault_clear = 1'b0;
    logic [15:0] period_ms = 16'd0;
    logic        hb_ack = 1'b0;
    logic        hb_req;
    logic        hb_pulse;
    logic [15:0] hb_count;
    logic [3:0]  missed_count;
    logic        fault;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    bit load_ffff = 1'b0;

    heartbeat_generator #(
        .CLK_FREQ(1000),
        .MAX_MISSED(MAXM),
        .ACK_TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .pause(pause),
        .fault_clear(fault_clear),
        .period_ms(period_ms),
        .hb_ack(hb_ack),
        .hb_req(hb_req),
        .hb_pulse(hb_pulse),
        .hb_count(hb_count),
        .missed_count(missed_count),
        .fault(fault),
        .state(state)
    );

    always #5 clk = ~clk;

    // Model: a WAIT interval is a budget of un-paused cycles; a request ages until ack or timeout.
    int m_mode = 0;
    int wait_left = 0;
    int req_age = 0;
    int m_count = 0;
    int m_missed = 0;
    int m_fault = 0;
    int m_req = 0;
    int m_pulse = 0;

    task automatic start_interval();
        m_mode = 1;
        wait_left = ((period_ms == 16'd0) ? 1 : int'(period_ms)) * CPM;
    endtask

    always @(posedge clk) begin
        m_pulse = 0;
        if (rst) begin
            m_mode = 0; m_req = 0; m_fault = 0; m_count = 0; m_missed = 0;
        end else if (!enable) begin
            m_mode = 0; m_req = 0; m_fault = 0; m_missed = 0;
        end else if (m_mode == 0) begin
            start_interval();
        end else if (m_mode == 1) begin
            if (!pause) begin
                wait_left = wait_left - 1;
                if (wait_left == 0) begin
                    m_mode = 2; m_req = 1; req_age = 0;
                end
            end
        end else if (m_mode == 2) begin
            if (hb_ack) begin
                m_req = 0; m_pulse = 1; m_missed = 0;
                m_count = (m_count + 1) % 65536;
                start_interval();
            end else begin
                req_age = req_age + 1;
                if (req_age == TMO) begin
                    m_req = 0;
                    m_missed = (m_missed + 1 > MAXM) ? MAXM : m_missed + 1;
                    if (m_missed == MAXM) begin
                        m_mode = 3; m_fault = 1;
                    end else begin
                        start_interval();
                    end
                end
            end
        end else if (fault_clear) begin
            m_fault = 0; m_missed = 0;
            start_interval();
        end
        if (load_ffff) m_count = 65535;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (int'(state) != m_mode || int'(hb_req) != m_req || int'(hb_pulse) != m_pulse ||
                (!load_ffff && int'(hb_count) != m_count) || int'(missed_count) != m_missed ||
                int'(fault) != m_fault) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t got st=%0d req=%0d pul=%0d cnt=%0d miss=%0d flt=%0d exp st=%0d req=%0d pul=%0d cnt=%0d miss=%0d flt=%0d",
                         $time, state, hb_req, hb_pulse, hb_count, missed_count, fault,
                         m_mode, m_req, m_pulse, m_count, m_missed, m_fault);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_req(input int budget, output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!hb_req && n < budget);
    endtask

    task automatic req_len(input int budget, output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (hb_req && n < budget);
    endtask

    int n;

    initial begin
        tick(2);
        check("reset_state", int'(state), 0);
        check("reset_req", int'(hb_req), 0);
        check("reset_count", int'(hb_count), 0);
        chk_en = 1'b1;

        // 1: from IDLE the enable edge plus 5 WAIT cycles; later intervals 5 cycles from ack
        rst = 1'b0; enable = 1'b1; period_ms = 16'd5;
        for (int i = 0; i < 3; i++) begin
            wait_req(40, n);
            check("t1_wait", n, (i == 0) ? 6 : 5);
            tick(1);
            hb_ack = 1'b1;
            tick(1);
            hb_ack = 1'b0;
            check("t1_pulse", int'(hb_pulse), 1);
            check("t1_count", int'(hb_count), i + 1);
        end

        // 2: no ack, three timeouts into FAULT
        period_ms = 16'd4;
        for (int i = 0; i < 3; i++) begin
            wait_req(40, n);
            check("t2_wait", n, (i == 0) ? 5 : 4);
            req_len(40, n);
            check("t2_req_len", n, 8);
            check("t2_missed", int'(missed_count), i + 1);
        end
        check("t2_fault", int'(fault), 1);
        check("t2_state", int'(state), 3);

        // 3: fault_clear, then one acked request
        fault_clear = 1'b1;
        tick(1);
        fault_clear = 1'b0;
        check("t3_state", int'(state), 1);
        check("t3_missed", int'(missed_count), 0);
        wait_req(40, n);
        check("t3_wait", n, 4);
        hb_ack = 1'b1;
        tick(1);
        hb_ack = 1'b0;
        check("t3_count", int'(hb_count), 4);

        // 4: pause 10 cycles mid-WAIT plus a stray ack
        period_ms = 16'd5;
        wait_req(40, n);
        hb_ack = 1'b1;
        tick(1);
        hb_ack = 1'b0;
        tick(2);
        pause = 1'b1;
        tick(4);
        hb_ack = 1'b1;
        tick(1);
        hb_ack = 1'b0;
        tick(5);
        pause = 1'b0;
        check("t4_stray_ack_count", int'(hb_count), 5);
        wait_req(40, n);
        check("t4_paused_wait", n, 3);
        hb_ack = 1'b1;
        tick(1);
        hb_ack = 1'b0;
        check("t4_count", int'(hb_count), 6);

        // 5: enable drop mid-REQ, then reset mid-REQ
        wait_req(40, n);
        enable = 1'b0;
        tick(1);
        check("t5_req", int'(hb_req), 0);
        check("t5_state", int'(state), 0);
        check("t5_count", int'(hb_count), 6);
        enable = 1'b1;
        wait_req(40, n);
        check("t5_wait", n, 6);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t5_rst_req", int'(hb_req), 0);
        check("t5_rst_count", int'(hb_count), 0);
        check("t5_rst_state", int'(state), 0);

        // 6: period 0 acts as 1, ack on the final timeout cycle, counter wrap
        period_ms = 16'd0;
        wait_req(40, n);
        check("t6_p0_wait", n, 2);
        tick(8);
        check("t6_missed", int'(missed_count), 1);
        wait_req(40, n);
        check("t6_p0_wait2", n, 1);
        tick(7);
        period_ms = 16'd20;
        hb_ack = 1'b1;
        tick(1);
        hb_ack = 1'b0;
        check("t6_late_ack_pulse", int'(hb_pulse), 1);
        check("t6_late_ack_missed", int'(missed_count), 0);
        check("t6_late_ack_count", int'(hb_count), 1);
        tick(2);
        force dut.hb_count = 16'hFFFF;
        load_ffff = 1'b1;
        tick(1);
        release dut.hb_count;
        load_ffff = 1'b0;
        tick(1);
        check("t6_preload", int'(hb_count), 65535);
        wait_req(40, n);
        hb_ack = 1'b1;
        tick(1);
        hb_ack = 1'b0;
        check("t6_wrap", int'(hb_count), 0);

        enable = 1'b0;
        tick(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
